pattern_checker: RTL and testbench

//  Downstream consumer of pattern_generator: samples its IO_SIZE_G-bit output, locks to
//  the fixed 12-entry sequence, flags every deviation and counts errors. Used in the
//  TMR test system to detect upsets in the generator and in the lanes it drives.

---
 rtl/pattern_checker.sv | 146 ++++++++++++++
 tb/tb_pattern_checker.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pattern_checker.sv
// Locks onto the 12-entry pattern_generator sequence and counts deviations.
// Error count saturates; clear_i wipes it without touching lock state.
module pattern_checker #(
  parameter int IO_SIZE_G       = 3,
  parameter int LOCK_COUNT_G    = 12,
  parameter int UNLOCK_THRESH_G = 4,
  parameter int CNT_WIDTH_G     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [IO_SIZE_G-1:0]   data_i,
  output logic                   locked_o,
  output logic                   error_o,
  output logic [CNT_WIDTH_G-1:0] error_count_o
);

  localparam logic [IO_SIZE_G-1:0] IDLE = IO_SIZE_G'(0);
  localparam logic [IO_SIZE_G-1:0] S1_A = IO_SIZE_G'(1);
  localparam logic [IO_SIZE_G-1:0] S1_B = IO_SIZE_G'(2);
  localparam logic [IO_SIZE_G-1:0] S1_C = IO_SIZE_G'(3);
  localparam logic [IO_SIZE_G-1:0] S2_A = IO_SIZE_G'(4);
  localparam logic [IO_SIZE_G-1:0] S2_B = IO_SIZE_G'(5);
  localparam logic [IO_SIZE_G-1:0] S2_C = IO_SIZE_G'(6);

  localparam int MW = $clog2(LOCK_COUNT_G + 1);
  localparam int XW = $clog2(UNLOCK_THRESH_G + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT_G);
  localparam logic [XW-1:0] MISS_N = XW'(UNLOCK_THRESH_G);
  localparam logic [CNT_WIDTH_G-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNC     = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t               state_q;
  logic [3:0]           idx_q;
  logic [MW-1:0]        match_q;
  logic [XW-1:0]        miss_q;
  logic [IO_SIZE_G-1:0] prev_q;

  logic [IO_SIZE_G-1:0] exp;
  logic [3:0]           idx_inc;
  logic [MW-1:0]        match_inc;
  logic [XW-1:0]        miss_inc;
  logic                 hit;
  logic                 start;
  logic                 bump;

  function automatic logic [IO_SIZE_G-1:0] seq_at(
    input logic [3:0] i
  );
    case (i)
      4'd0, 4'd3:  seq_at = S2_A;
      4'd1, 4'd4:  seq_at = S2_B;
      4'd2, 4'd5:  seq_at = S2_C;
      4'd6, 4'd9:  seq_at = S1_A;
      4'd7, 4'd10: seq_at = S1_B;
      default:     seq_at = S1_C;
    endcase
  endfunction

  assign exp       = seq_at(idx_q);
  assign idx_inc   = (idx_q == 4'd11) ? 4'd0 : idx_q + 4'd1;
  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + XW'(1);
  assign hit       = (data_i == exp);
  // S2_A right after IDLE or S1_C only occurs at index 0
  assign start     = (data_i == S2_A) &&
                     ((prev_q == IDLE) || (prev_q == S1_C));
  assign bump      = (state_q == LOCKED) && !hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= UNLOCKED;
      idx_q         <= 4'd0;
      match_q       <= '0;
      miss_q        <= '0;
      prev_q        <= IDLE;
      locked_o      <= 1'b0;
      error_o       <= 1'b0;
      error_count_o <= '0;
    end else begin
      prev_q  <= data_i;
      error_o <= bump;

      // clear wins first, then a same-cycle mismatch still counts
      if (clear_i)
        error_count_o <= bump ? CNT_WIDTH_G'(1) : '0;
      else if (bump && error_count_o != CNT_MAX)
        error_count_o <= error_count_o + CNT_WIDTH_G'(1);

      unique case (state_q)
        UNLOCKED: begin
          if (start) begin
            idx_q <= 4'd1;
            if (LOCK_COUNT_G == 1) begin
              state_q  <= LOCKED;
              locked_o <= 1'b1;
              match_q  <= '0;
            end else begin
              state_q <= SYNC;
              match_q <= MW'(1);
            end
          end
        end
        SYNC: begin
          if (hit) begin
            idx_q <= idx_inc;
            if (match_inc == LOCK_N) begin
              state_q  <= LOCKED;
              locked_o <= 1'b1;
              match_q  <= '0;
            end else begin
              match_q <= match_inc;
            end
          end else begin
            state_q <= UNLOCKED;
            match_q <= '0;
            idx_q   <= 4'd0;
          end
        end
        LOCKED: begin
          idx_q <= idx_inc;
          if (hit) begin
            miss_q <= '0;
          end else if (miss_inc == MISS_N) begin
            state_q  <= UNLOCKED;
            locked_o <= 1'b0;
            miss_q   <= '0;
            idx_q    <= 4'd0;
          end else begin
            miss_q <= miss_inc;
          end
        end
        default: begin
          state_q  <= UNLOCKED;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_checker.sv
// Directed vector bench for pattern_checker; a 2-bit-counter twin
// shares all inputs so counter saturation is reachable quickly.
module tb_pattern_checker;

  typedef struct {
    logic [2:0]  d;
    logic        clr;
    logic        l;
    logic        e;
    logic [15:0] c;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [2:0]  data;
  logic        locked;
  logic        error;
  logic [15:0] count;
  logic        s_locked;
  logic        s_error;
  logic [1:0]  s_count;

  int applied = 0;
  int miscompares = 0;

  vec_t       vq[$];
  logic [2:0] pat[12];

  pattern_checker dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
    .locked_o(locked), .error_o(error), .error_count_o(count)
  );

  pattern_checker #(.CNT_WIDTH_G(2)) sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
    .locked_o(s_locked), .error_o(s_error), .error_count_o(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [2:0] d, input logic clr,
                     input logic l, input logic e, input int c);
    vec_t v;
    v.d = d; v.clr = clr; v.l = l; v.e = e; v.c = 16'(c);
    vq.push_back(v);
  endtask

  task automatic step(input logic [2:0] d, input logic clr);
    @(negedge clk);
    data = d;
    clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic l,
                       input logic e, input logic [15:0] c);
    logic [1:0] sc;
    sc = (c > 16'd3) ? 2'd3 : c[1:0];
    applied++;
    if (locked !== l || error !== e || count !== c ||
        s_locked !== l || s_error !== e || s_count !== sc) begin
      miscompares++;
      $display("FAIL %s: got locked=%0b err=%0b cnt=%0d sat=%0d, want %0b %0b %0d %0d",
               nm, locked, error, count, s_count, l, e, c, sc);
    end
  endtask

  initial begin
    int c;
    pat = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6,
            3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
    rst_n = 1'b0;
    clear = 1'b0;
    data  = 3'd0;

    add(3'd0, 0, 0, 0, 0);
    add(3'd0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) add(pat[k], 0, k == 11, 0, 0);
    for (int k = 12; k < 108; k++) add(pat[k % 12], 0, 1, 0, 0);
    add(pat[0], 0, 1, 0, 0);
    add(3'd7, 0, 1, 1, 1);
    for (int k = 2; k < 12; k++) add(pat[k], 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(3'd0, 0, i < 3, 1, 2 + i);
    for (int k = 0; k < 12; k++) add(pat[k], 0, k == 11, 0, 5);
    add(3'd7, 1, 1, 1, 1);
    for (int k = 1; k < 12; k++) add(pat[k], 0, 1, 0, 1);
    c = 1;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0 && k <= 4) begin
        c++;
        add(3'd7, 0, 1, 1, c);
      end else begin
        add(pat[k], 0, 1, 0, c);
      end
    end
    for (int i = 0; i < 4; i++) add(3'd0, 0, i < 3, 1, 5 + i);
    for (int k = 0; k < 5; k++) add(pat[k], 0, 0, 0, 8);
    add(3'd1, 0, 0, 0, 8);
    for (int k = 2; k < 12; k++) add(pat[k], 0, 0, 0, 8);
    for (int k = 0; k < 12; k++) add(pat[k], 0, k == 11, 0, 8);

    @(posedge clk);
    #1;
    check("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].d, vq[i].clr);
      check($sformatf("vec%0d", i), vq[i].l, vq[i].e, vq[i].c);
    end

    step(3'd7, 0);
    check("err_before_rst", 1, 1, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd0, 0);
    check("post_rst_idle", 0, 0, 0);
    for (int k = 0; k < 12; k++) step(pat[k], 0);
    check("post_rst_relock", 1, 0, 0);
    step(pat[0], 0);
    check("post_rst_wrap", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
